// File: rtl/uart_tx.sv
// uart_tx: ena-paced UART transmitter, 8 data bits LSB first, optional parity, 1 or 2 stop bits
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int PW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT} state_t;
  state_t state;
  logic [PW-1:0] pre;
  logic [2:0] cnt;
  logic [7:0] sh;
  logic par;
  logic wrap;
  assign wrap = ena && pre == PW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pre <= '0;
      cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      tx <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && ena) pre <= wrap ? '0 : pre + 1'b1;
      case (state)
        IDLE: if (start && ena) begin
          sh <= data_in;
          par <= PARITY == 2 ? ~^data_in : ^data_in;
          pre <= '0;
          cnt <= '0;
          state <= START_BIT;
          tx <= 1'b0;
          busy <= 1'b1;
        end
        START_BIT: if (wrap) begin
          state <= DATA_BITS;
          tx <= sh[0];
        end
        DATA_BITS: if (wrap) begin
          if (cnt == 3'd7) begin
            cnt <= '0;
            state <= PARITY != 0 ? PARITY_BIT : STOP_BIT;
            tx <= PARITY != 0 ? par : 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            tx <= sh[1];
            sh <= {1'b0, sh[7:1]};
          end
        end
        PARITY_BIT: if (wrap) begin
          state <= STOP_BIT;
          tx <= 1'b1;
        end
        STOP_BIT: if (wrap) begin
          if (cnt == 3'(STOP_BITS - 1)) begin
            cnt <= '0;
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
